// File: rtl/interval_loader_if.sv
// Request channel into the interval loader.
// Valid/ready handshake carrying a new interval in minutes.
interface interval_loader_if;
  logic        req_valid;
  logic [15:0] req_interval;
  logic        req_ready;

  modport master (
    output req_valid,
    output req_interval,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_interval,
    output req_ready
  );
endinterface

// File: rtl/interval_loader.sv
// Interval loader: range-checks a request and reloads the interval counter.
// Define INTERVAL_LOADER_SAFE_WAIT_EN to hold the load off while switch_i_c is high.
module interval_loader #(
  parameter int DEFAULT_INTERVAL = 10,
  parameter int MIN_INTERVAL     = 1,
  parameter int MAX_INTERVAL     = 1440,
  parameter int RESET_HOLD       = 2
) (
  input  logic               clock,
  input  logic               reset,
  interval_loader_if.slave   req,
  input  logic               switch_i_c,
  output logic [15:0]        interval,
  output logic               interval_reset,
  output logic               load_done,
  output logic               load_error,
  output logic               busy
);

  localparam int HW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [15:0] DEF_V = 16'(DEFAULT_INTERVAL);
  localparam logic [15:0] MIN_V = 16'(MIN_INTERVAL);
  localparam logic [15:0] MAX_V = 16'(MAX_INTERVAL);
  localparam logic [HW-1:0] HOLD_V = HW'(RESET_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t        r_state;
  state_t        w_state_n;
  logic [15:0]   r_cap;
  logic [15:0]   w_cap_n;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_n;
  logic [15:0]   r_interval;
  logic [15:0]   w_interval_n;
  logic          r_ireset;
  logic          w_ireset_n;
  logic          r_done;
  logic          w_done_n;
  logic          r_err;
  logic          w_err_n;
  logic          r_busy;
  logic          w_ready;
  logic          w_accept;
  logic          w_bad;
  logic          w_safe;

  assign w_ready  = (r_state == S_IDLE);
  assign w_accept = req.req_valid & w_ready;
  assign w_bad    = (r_cap == 16'd0) | (r_cap < MIN_V) | (r_cap > MAX_V);

`ifdef INTERVAL_LOADER_SAFE_WAIT_EN
  assign w_safe = ~switch_i_c;
`else
  // switch window is ignored; the term only keeps the port referenced
  assign w_safe = 1'b1 | switch_i_c;
`endif

  always_comb begin
    w_state_n    = r_state;
    w_cap_n      = r_cap;
    w_hold_n     = r_hold;
    w_interval_n = r_interval;
    w_ireset_n   = r_ireset;
    w_done_n     = 1'b0;
    w_err_n      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cap_n   = req.req_interval;
          w_state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_bad) begin
          w_err_n   = 1'b1;
          w_state_n = S_IDLE;
        end else begin
          w_state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_safe) begin
          w_interval_n = r_cap;
          w_ireset_n   = 1'b1;
          w_hold_n     = HOLD_V;
          w_state_n    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_hold != '0) begin
          w_hold_n = r_hold - 1'b1;
        end else begin
          w_ireset_n = 1'b0;
          w_done_n   = 1'b1;
          w_state_n  = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cap      <= '0;
      r_hold     <= '0;
      r_interval <= DEF_V;
      r_ireset   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cap      <= w_cap_n;
      r_hold     <= w_hold_n;
      r_interval <= w_interval_n;
      r_ireset   <= w_ireset_n;
      r_done     <= w_done_n;
      r_err      <= w_err_n;
      r_busy     <= (w_state_n != S_IDLE);
    end
  end

  assign req.req_ready   = w_ready;
  assign interval        = r_interval;
  assign interval_reset  = r_ireset;
  assign load_done       = r_done;
  assign load_error      = r_err;
  assign busy            = r_busy;

endmodule
